// File: rtl/vram_line_fetch.sv
// Scanline prefetch: streams LINE_WORDS SRAM words, packs pairs into 32-bit linebuffer entries.
// Latency: first write READ_LAT+4 cycles after start; no backpressure (SRAM and linebuffer are fixed-timing).
module vram_line_fetch #(
   parameter int LINE_WORDS  = 320,
   parameter int LINE_STRIDE = 320,
   parameter int READ_LAT    = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start_i,
   input  logic [9:0]  line_i,
   input  logic        bank_i,
   input  logic [17:0] fb_base_i,
   output logic        busy_o,
   output logic        done_o,
   output logic [17:0] v_adr_o,
   output logic        v_oe_sram_o,
   output logic        v_we_o,
   input  logic [15:0] v_dat_i,
   output logic [8:0]  lbw_adr_o,
   output logic [31:0] lbw_dat_o,
   output logic        lbw_we_o
);

   typedef enum logic [2:0] {IDLE, SETUP, READ, DRAIN, DONE} state_t;

   state_t              state;
   logic [9:0]          line_q;
   logic                bank_q;
   logic [17:0]         base_q;
   logic [17:0]         line_addr;
   logic [9:0]          cnt;
   logic [READ_LAT-1:0] rd_pipe;
   logic                odd_q;
   logic [15:0]         lo_q;
   logic [7:0]          entry_q;

   assign line_addr = base_q + 18'(line_q) * 18'(LINE_STRIDE);
   assign v_we_o    = 1'b0;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         busy_o      <= 1'b0;
         done_o      <= 1'b0;
         v_oe_sram_o <= 1'b0;
         v_adr_o     <= '0;
         cnt         <= '0;
         line_q      <= '0;
         bank_q      <= 1'b0;
         base_q      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start_i) begin
                  line_q <= line_i;
                  bank_q <= bank_i;
                  base_q <= fb_base_i;
                  busy_o <= 1'b1;
                  state  <= SETUP;
               end
            end
            SETUP: begin
               v_adr_o     <= line_addr;
               v_oe_sram_o <= 1'b1;
               cnt         <= '0;
               state       <= READ;
            end
            READ: begin
               // Address stays on the last word through DRAIN.
               if (cnt == 10'(LINE_WORDS - 1)) begin
                  v_oe_sram_o <= 1'b0;
                  cnt         <= '0;
                  state       <= DRAIN;
               end else begin
                  v_adr_o <= v_adr_o + 18'd1;
                  cnt     <= cnt + 10'd1;
               end
            end
            DRAIN: begin
               if (cnt == 10'(READ_LAT - 1)) begin
                  done_o <= 1'b1;
                  state  <= DONE;
               end else begin
                  cnt <= cnt + 10'd1;
               end
            end
            DONE: begin
               done_o <= 1'b0;
               busy_o <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // rd_pipe tracks which cycles carry valid SRAM data, READ_LAT cycles behind the address.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_pipe   <= '0;
         odd_q     <= 1'b0;
         lo_q      <= '0;
         entry_q   <= '0;
         lbw_adr_o <= '0;
         lbw_dat_o <= '0;
         lbw_we_o  <= 1'b0;
      end else begin
         rd_pipe[0] <= (state == READ);
         for (int i = 1; i < READ_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
         lbw_we_o <= 1'b0;
         if (state == SETUP) begin
            odd_q   <= 1'b0;
            entry_q <= '0;
         end else if (rd_pipe[READ_LAT-1]) begin
            if (!odd_q) begin
               lo_q  <= v_dat_i;
               odd_q <= 1'b1;
            end else begin
               lbw_dat_o <= {v_dat_i, lo_q};
               lbw_adr_o <= {bank_q, entry_q};
               lbw_we_o  <= 1'b1;
               entry_q   <= entry_q + 8'd1;
               odd_q     <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_vram_line_fetch.sv
// Directed bench for vram_line_fetch: READ_LAT=1 and READ_LAT=2 instances on shared stimulus.
module tb_vram_line_fetch;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, start_i, bank_i;
   logic [9:0]  line_i;
   logic [17:0] fb_base_i;

   logic        busy1, done1, oe1, we1, lbw_we1;
   logic [17:0] v_adr1;
   logic [8:0]  lbw_adr1;
   logic [31:0] lbw_dat1;
   logic [15:0] sram1;

   logic        busy2, done2, oe2, we2, lbw_we2;
   logic [17:0] v_adr2;
   logic [8:0]  lbw_adr2;
   logic [31:0] lbw_dat2;
   logic [15:0] sram2a, sram2b;

   vram_line_fetch #(.LINE_WORDS(320), .LINE_STRIDE(320), .READ_LAT(1)) u_dut (
      .clk(clk), .rst_n(rst_n), .start_i(start_i), .line_i(line_i), .bank_i(bank_i),
      .fb_base_i(fb_base_i), .busy_o(busy1), .done_o(done1), .v_adr_o(v_adr1),
      .v_oe_sram_o(oe1), .v_we_o(we1), .v_dat_i(sram1), .lbw_adr_o(lbw_adr1),
      .lbw_dat_o(lbw_dat1), .lbw_we_o(lbw_we1));

   vram_line_fetch #(.LINE_WORDS(320), .LINE_STRIDE(320), .READ_LAT(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .start_i(start_i), .line_i(line_i), .bank_i(bank_i),
      .fb_base_i(fb_base_i), .busy_o(busy2), .done_o(done2), .v_adr_o(v_adr2),
      .v_oe_sram_o(oe2), .v_we_o(we2), .v_dat_i(sram2b), .lbw_adr_o(lbw_adr2),
      .lbw_dat_o(lbw_dat2), .lbw_we_o(lbw_we2));

   // SRAM model: data equals the low 16 address bits, returned after the configured latency.
   always @(posedge clk) begin
      sram1  <= v_adr1[15:0];
      sram2a <= v_adr2[15:0];
      sram2b <= sram2a;
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   int          wr_cyc[$];
   logic [8:0]  wr_adr[$];
   logic [31:0] wr_dat[$];
   int          done_q[$];
   int          w2_cyc[$];
   logic [31:0] w2_dat[$];
   int          d2_q[$];
   logic [17:0] adr_c[5];
   logic        busy_c1, oe_c2;

   // Called at a negedge; start_i is sampled at the next posedge (cycle 0 ends there).
   task automatic run_fetch(input logic [17:0] base, input logic [9:0] line, input logic bank,
                            input int p1, input int p2, input logic pbank, input int budget);
      wr_cyc.delete(); wr_adr.delete(); wr_dat.delete(); done_q.delete();
      w2_cyc.delete(); w2_dat.delete(); d2_q.delete();
      fb_base_i = base;
      line_i    = line;
      bank_i    = bank;
      start_i   = 1'b1;
      for (int cyc = 1; cyc <= budget; cyc++) begin
         @(negedge clk);
         start_i = (cyc == p1) || (cyc == p2);
         if (start_i) bank_i = pbank;
         if (cyc < 5) adr_c[cyc] = v_adr1;
         if (cyc == 1) busy_c1 = busy1;
         if (cyc == 2) oe_c2 = oe1;
         if (lbw_we1) begin
            wr_cyc.push_back(cyc);
            wr_adr.push_back(lbw_adr1);
            wr_dat.push_back(lbw_dat1);
         end
         if (done1) done_q.push_back(cyc);
         if (lbw_we2) begin
            w2_cyc.push_back(cyc);
            w2_dat.push_back(lbw_dat2);
         end
         if (done2) d2_q.push_back(cyc);
      end
      start_i = 1'b0;
   endtask

   int errs;
   int nwe;

   initial begin
      rst_n = 1'b0; start_i = 1'b0; bank_i = 1'b0; line_i = '0; fb_base_i = '0;
      repeat (3) @(negedge clk);
      chk("rst_adr", 64'(v_adr1), 64'h0);
      chk("rst_ctl", 64'({busy1, done1, oe1, we1, lbw_we1}), 64'h0);
      chk("rst_lbw", 64'({lbw_adr1, lbw_dat1}), 64'h0);
      rst_n = 1'b1;
      @(negedge clk);

      // Basic fetch, bank 1
      run_fetch(18'h00100, 10'd2, 1'b1, 0, 0, 1'b1, 340);
      chk("t1_busy_c1", 64'(busy_c1), 64'h1);
      chk("t1_oe_c2", 64'(oe_c2), 64'h1);
      chk("t1_adr_c2", 64'(adr_c[2]), 64'h00380);
      chk("t1_nwr", 64'(wr_adr.size()), 64'd160);
      chk("t1_wr0_cyc", 64'(wr_cyc[0]), 64'd5);
      chk("t1_wr0_adr", 64'(wr_adr[0]), 64'h100);
      chk("t1_wr0_dat", 64'(wr_dat[0]), 64'h0381_0380);
      chk("t1_last_adr", 64'(wr_adr[wr_adr.size()-1]), 64'h19F);
      chk("t1_ndone", 64'(done_q.size()), 64'd1);
      chk("t1_done_cyc", 64'(done_q[0]), 64'd323);
      chk("t1_last_cyc", 64'(wr_cyc[wr_cyc.size()-1]), 64'd323);
      errs = 0;
      for (int i = 0; i < wr_adr.size(); i++) begin
         logic [15:0] w0;
         w0 = 16'(16'h0380 + 2 * i);
         if (wr_adr[i] !== {1'b1, 8'(i)} || wr_dat[i] !== {w0 + 16'd1, w0}) errs++;
      end
      chk("t1_seq_errs", 64'(errs), 64'd0);

      // Address wrap at top of SRAM
      run_fetch(18'h3FFFF, 10'd0, 1'b0, 0, 0, 1'b0, 340);
      chk("t2_adr_c2", 64'(adr_c[2]), 64'h3FFFF);
      chk("t2_adr_c3", 64'(adr_c[3]), 64'h00000);
      chk("t2_adr_c4", 64'(adr_c[4]), 64'h00001);
      chk("t2_wr0_adr", 64'(wr_adr[0]), 64'h000);
      chk("t2_wr0_dat", 64'(wr_dat[0]), 64'h0000_FFFF);

      // Starts during READ and DONE are ignored
      run_fetch(18'h00100, 10'd2, 1'b1, 5, 323, 1'b1, 340);
      chk("t3_ndone", 64'(done_q.size()), 64'd1);
      chk("t3_nwr", 64'(wr_adr.size()), 64'd160);
      chk("t3_done_cyc", 64'(done_q[0]), 64'd323);

      // Mid-fetch reset
      fb_base_i = 18'h00100; line_i = 10'd2; bank_i = 1'b1; start_i = 1'b1;
      nwe = 0;
      for (int cyc = 1; cyc <= 60; cyc++) begin
         @(negedge clk);
         start_i = 1'b0;
         if (cyc == 50) rst_n = 1'b0;
         if (cyc == 51) begin
            chk("t4_adr", 64'(v_adr1), 64'h0);
            chk("t4_ctl", 64'({busy1, done1, oe1, we1, lbw_we1}), 64'h0);
            chk("t4_lbw", 64'({lbw_adr1, lbw_dat1}), 64'h0);
         end
         if (cyc == 52) rst_n = 1'b1;
         if (cyc >= 51 && lbw_we1) nwe++;
      end
      chk("t4_no_we", 64'(nwe), 64'd0);
      run_fetch(18'h00100, 10'd2, 1'b1, 0, 0, 1'b1, 340);
      chk("t4_re_nwr", 64'(wr_adr.size()), 64'd160);
      chk("t4_re_done", 64'(done_q[0]), 64'd323);

      // READ_LAT=2 instance timing
      run_fetch(18'h00000, 10'd1, 1'b0, 0, 0, 1'b0, 340);
      chk("t5_wr0_cyc", 64'(w2_cyc[0]), 64'd6);
      chk("t5_wr0_dat", 64'(w2_dat[0]), 64'h0141_0140);
      chk("t5_nwr", 64'(w2_dat.size()), 64'd160);
      chk("t5_done_cyc", 64'(d2_q[0]), 64'd324);
      chk("t5_rl1_done", 64'(done_q[0]), 64'd323);

      // Back-to-back start the cycle after done, switching to bank 0
      run_fetch(18'h00100, 10'd2, 1'b1, 324, 0, 1'b0, 700);
      chk("t6_ndone", 64'(done_q.size()), 64'd2);
      chk("t6_done2_cyc", 64'(done_q[1]), 64'd647);
      chk("t6_nwr", 64'(wr_adr.size()), 64'd320);
      chk("t6_wr160_adr", 64'(wr_adr[160]), 64'h000);
      errs = 0;
      for (int i = 160; i < wr_adr.size(); i++) if (wr_adr[i][8] !== 1'b0) errs++;
      chk("t6_bank_errs", 64'(errs), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
